// File: rtl/pio_mem_bridge_if.sv
// PIO host bus and memory-slave bus bundle for pio_mem_bridge.
// slave = bridge view, master = host/memory side view.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

interface pio_mem_bridge_if #(
   parameter int NUM_MEM = 4
);
   logic                          pio_req;
   logic                          pio_rw;
   logic [`PIO_NBITS-1:0]         pio_addr;
   logic [`PIO_NBITS-1:0]         pio_wdata;
   logic                          pio_busy;
   logic                          pio_ack;
   logic                          pio_err;
   logic [`PIO_NBITS-1:0]         pio_rdata;
   logic [15:0]                   err_cnt;
   logic [`PIO_NBITS-1:0]         reg_addr;
   logic [`PIO_NBITS-1:0]         reg_din;
   logic                          reg_rd;
   logic                          reg_wr;
   logic [NUM_MEM-1:0]            reg_ms;
   logic [NUM_MEM-1:0]            mem_ack;
   logic [NUM_MEM*`PIO_NBITS-1:0] mem_rdata;

   modport slave (
      input  pio_req, pio_rw, pio_addr, pio_wdata,
      input  mem_ack, mem_rdata,
      output pio_busy, pio_ack, pio_err, pio_rdata, err_cnt,
      output reg_addr, reg_din, reg_rd, reg_wr, reg_ms
   );

   modport master (
      output pio_req, pio_rw, pio_addr, pio_wdata,
      output mem_ack, mem_rdata,
      input  pio_busy, pio_ack, pio_err, pio_rdata, err_cnt,
      input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms
   );
endinterface

// File: rtl/pio_mem_bridge.sv
// PIO target bridge: decodes a host request onto one of NUM_MEM slaves,
// strobes it, waits for its stretched ack (with timeout) and responds.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module pio_mem_bridge #(
   parameter int                    NUM_MEM   = 4,
   parameter int                    SEL_LSB   = 12,
   parameter int                    SEL_NBITS = 2,
   parameter int                    TO_NBITS  = 8,
   parameter logic [`PIO_NBITS-1:0] ERR_DATA  = 32'hBAD0_0BAD
) (
   input  logic                 clk,
   input  logic                 rst,
   pio_mem_bridge_if.slave      bus
);
   localparam int W = `PIO_NBITS;
   localparam logic [SEL_NBITS:0] NM =
      (SEL_NBITS+1)'(NUM_MEM);
   localparam logic [TO_NBITS-1:0] TO_LAST =
      {{(TO_NBITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      IDLE, PRE, WAIT, RESP
   } state_t;

   state_t               state;
   logic                 rw_q;
   logic                 err_q;
   logic [SEL_NBITS-1:0] sel_q;
   logic [TO_NBITS-1:0]  to_cnt;
   logic [W-1:0]         rdata_q;

   logic [SEL_NBITS-1:0] req_sel;
   logic                 req_bad;
   logic [NUM_MEM-1:0]   req_ms;
   logic                 ack_sel;
   logic [W-1:0]         rdata_sel;
   logic                 to_fire;

   assign req_sel = bus.pio_addr[SEL_LSB +: SEL_NBITS];
   assign req_bad = {1'b0, req_sel} >= NM;
   // the cycle whose increment would reach all-ones is the last one allowed
   assign to_fire = (to_cnt == TO_LAST);

   // decode the incoming select and mux the latched slave's ack and data
   always_comb begin
      req_ms    = '0;
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (req_sel == SEL_NBITS'(i))
            req_ms[i] = 1'b1;
         if (sel_q == SEL_NBITS'(i)) begin
            ack_sel   = bus.mem_ack[i];
            rdata_sel = bus.mem_rdata[i*W +: W];
         end
      end
   end

   // request sequencer: accept, wait for stale ack to clear, strobe,
   // wait for ack or timeout, then pulse the host completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rw_q          <= 1'b0;
         err_q         <= 1'b0;
         sel_q         <= '0;
         to_cnt        <= '0;
         rdata_q       <= '0;
         bus.pio_busy  <= 1'b0;
         bus.pio_ack   <= 1'b0;
         bus.pio_err   <= 1'b0;
         bus.pio_rdata <= '0;
         bus.err_cnt   <= '0;
         bus.reg_addr  <= '0;
         bus.reg_din   <= '0;
         bus.reg_rd    <= 1'b0;
         bus.reg_wr    <= 1'b0;
         bus.reg_ms    <= '0;
      end else begin
         bus.reg_rd  <= 1'b0;
         bus.reg_wr  <= 1'b0;
         bus.pio_ack <= 1'b0;
         bus.pio_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.pio_req) begin
                  rw_q         <= bus.pio_rw;
                  sel_q        <= req_sel;
                  bus.reg_addr <= bus.pio_addr;
                  bus.reg_din  <= bus.pio_wdata;
                  bus.pio_busy <= 1'b1;
                  if (req_bad) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else begin
                     err_q      <= 1'b0;
                     bus.reg_ms <= req_ms;
                     to_cnt     <= '0;
                     state      <= PRE;
                  end
               end
            end
            PRE: begin
               to_cnt <= to_cnt + 1'b1;
               if (to_fire) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else if (!ack_sel) begin
                  bus.reg_rd <= ~rw_q;
                  bus.reg_wr <= rw_q;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (to_fire) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else if (ack_sel) begin
                  rdata_q <= rdata_sel;
                  state   <= RESP;
               end
            end
            RESP: begin
               bus.pio_ack  <= 1'b1;
               bus.pio_err  <= err_q;
               bus.reg_ms   <= '0;
               bus.pio_busy <= 1'b0;
               state        <= IDLE;
               if (err_q)
                  bus.pio_rdata <= ERR_DATA;
               else if (!rw_q)
                  bus.pio_rdata <= rdata_q;
               if (err_q && bus.err_cnt != 16'hFFFF)
                  bus.err_cnt <= bus.err_cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pio_mem_bridge.sv
// Self-checking bench for pio_mem_bridge with three emulated slaves,
// directed corner cases followed by randomized accesses.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module tb_pio_mem_bridge;
  localparam int          NM  = 3;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pio_mem_bridge_if #(.NUM_MEM(NM)) bif ();

  pio_mem_bridge #(.NUM_MEM(NM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd    = 0;
  int n_wr    = 0;
  int n_ack   = 0;
  int ack0;

  int            ack_dly = 1;
  logic          mute    = 1'b0;
  logic [NM-1:0] sl_ack;
  logic [NM-1:0] stale_ack = '0;
  logic          pend;
  int            dcnt;
  int            tgt;
  logic [31:0]   slave_word [NM];

  logic [31:0] model_word [NM];
  logic [31:0] exp_rdata;
  int          exp_ecnt;

  assign bif.mem_ack = sl_ack | stale_ack;
  for (genvar g = 0; g < NM; g++) begin : g_rd
    assign bif.mem_rdata[g*32 +: 32] =
      slave_word[g];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sl_ack        <= '0;
      pend          <= 1'b0;
      dcnt          <= 0;
      tgt           <= 0;
      slave_word[0] <= 32'h1111_0000;
      slave_word[1] <= 32'h0001_2345;
      slave_word[2] <= 32'h2222_0002;
    end else begin
      if (pend) begin
        if (dcnt <= 1) begin
          sl_ack[tgt] <= 1'b1;
          pend        <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end else if (sl_ack != '0) begin
        sl_ack <= '0;
      end
      if ((bif.reg_rd || bif.reg_wr) && !mute) begin
        pend <= 1'b1;
        dcnt <= ack_dly;
        for (int i = 0; i < NM; i++)
          if (bif.reg_ms[i]) tgt <= i;
      end
      if (bif.reg_wr)
        for (int i = 0; i < NM; i++)
          if (bif.reg_ms[i])
            slave_word[i] <= bif.reg_din;
    end
  end

  always @(negedge clk) begin
    if (bif.reg_rd === 1'b1)  n_rd  <= n_rd + 1;
    if (bif.reg_wr === 1'b1)  n_wr  <= n_wr + 1;
    if (bif.pio_ack === 1'b1) n_ack <= n_ack + 1;
  end

  function automatic void init_model();
    model_word[0] = 32'h1111_0000;
    model_word[1] = 32'h0001_2345;
    model_word[2] = 32'h2222_0002;
    exp_rdata     = '0;
    exp_ecnt      = 0;
  endfunction

  task automatic access(input logic rw,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input int dly,
                        input int stale,
                        input int dup_at);
    int   k, sk, sel, pre, exp_lat, exp_sk;
    int   rd0, wr0, a0;
    logic err, tmo;
    sel     = int'(addr[13:12]);
    err     = (sel >= NM);
    tmo     = !err && (mute || stale >= 255);
    pre     = (stale > 1) ? stale : 1;
    exp_sk  = (err || stale >= 255) ? 0 : pre + 1;
    exp_lat = err ? 2 :
              (tmo ? 257 : pre + 3 + dly);
    ack_dly = dly;
    rd0 = n_rd;
    wr0 = n_wr;
    a0  = n_ack;
    bif.pio_req   = 1'b1;
    bif.pio_rw    = rw;
    bif.pio_addr  = addr;
    bif.pio_wdata = wdata;
    if (!err && stale > 0) stale_ack[sel] = 1'b1;
    @(negedge clk);
    k  = 1;
    sk = 0;
    bif.pio_req = 1'b0;
    if (k >= stale) stale_ack = '0;
    chk("busy", bif.pio_busy, 1'b1);
    chk("reg_ms", bif.reg_ms,
        err ? 3'b000 : 3'(1 << sel));
    chk("reg_addr", bif.reg_addr, addr);
    if (rw) chk("reg_din", bif.reg_din, wdata);
    while (bif.pio_ack !== 1'b1 && k < 400) begin
      if ((bif.reg_rd | bif.reg_wr) === 1'b1 &&
          sk == 0) sk = k;
      @(negedge clk);
      k++;
      if (k >= stale) stale_ack = '0;
      bif.pio_req = (k == dup_at);
    end
    bif.pio_req = 1'b0;
    stale_ack   = '0;
    if (err || tmo) begin
      exp_rdata = ERR;
      exp_ecnt++;
    end else if (rw) begin
      model_word[sel] = wdata;
    end else begin
      exp_rdata = model_word[sel];
    end
    chk("latency", k, exp_lat);
    chk("strobe_cycle", sk, exp_sk);
    chk("pio_err", bif.pio_err, err || tmo);
    chk("pio_rdata", bif.pio_rdata, exp_rdata);
    chk("err_cnt", bif.err_cnt, 16'(exp_ecnt));
    @(negedge clk);
    chk("ack_pulses", n_ack - a0, 1);
    chk("rd_pulses", n_rd - rd0,
        (!rw && exp_sk != 0) ? 1 : 0);
    chk("wr_pulses", n_wr - wr0,
        (rw && exp_sk != 0) ? 1 : 0);
    chk("ack_low", bif.pio_ack, 1'b0);
    chk("idle", bif.pio_busy, 1'b0);
  endtask

  initial begin
    bif.pio_req   = 1'b0;
    bif.pio_rw    = 1'b0;
    bif.pio_addr  = '0;
    bif.pio_wdata = '0;
    init_model();
    repeat (3) @(negedge clk);
    chk("rst_busy", bif.pio_busy, 1'b0);
    chk("rst_ack", bif.pio_ack, 1'b0);
    chk("rst_err", bif.pio_err, 1'b0);
    chk("rst_rdata", bif.pio_rdata, 32'h0);
    chk("rst_errcnt", bif.err_cnt, 16'h0);
    chk("rst_addr", bif.reg_addr, 32'h0);
    chk("rst_din", bif.reg_din, 32'h0);
    chk("rst_strobe", bif.reg_rd | bif.reg_wr, 1'b0);
    chk("rst_ms", bif.reg_ms, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, 32'h0000_1008, 32'h0, 3, 0, 0);
    access(1'b1, 32'h0000_2010, 32'hA5A5_0F0F,
           1, 0, 0);
    access(1'b0, 32'h0000_2010, 32'h0, 2, 0, 0);

    access(1'b0, 32'h0000_0000, 32'h0, 1, 5, 0);

    mute = 1'b1;
    access(1'b0, 32'h0000_1004, 32'h0, 1, 0, 0);
    mute = 1'b0;
    ack0 = n_ack;
    stale_ack[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_ack", n_ack - ack0, 0);
    chk("late_busy", bif.pio_busy, 1'b0);
    access(1'b0, 32'h0000_1000, 32'h0, 2, 3, 0);

    access(1'b0, 32'h0000_0040, 32'h0, 1, 300, 0);

    access(1'b0, 32'h0000_3000, 32'h0, 1, 0, 0);
    access(1'b1, 32'h0000_3ABC, 32'h1234_5678,
           1, 0, 0);

    access(1'b0, 32'h0000_0000, 32'h0, 4, 0, 3);
    ack0 = n_ack;
    repeat (6) @(negedge clk);
    chk("dup_ack", n_ack - ack0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a        = $urandom;
      a[13:12] = 2'($urandom_range(3, 0));
      access(1'($urandom_range(1, 0)), a, $urandom,
             $urandom_range(4, 1),
             $urandom_range(3, 0), 0);
    end

    ack_dly = 10;
    ack0    = n_ack;
    bif.pio_req  = 1'b1;
    bif.pio_rw   = 1'b0;
    bif.pio_addr = 32'h0000_1000;
    @(negedge clk);
    bif.pio_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", bif.pio_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bif.pio_busy, 1'b0);
    chk("mid_rst_ms", bif.reg_ms, 3'b000);
    chk("mid_rst_addr", bif.reg_addr, 32'h0);
    chk("mid_rst_rdata", bif.pio_rdata, 32'h0);
    chk("mid_rst_errcnt", bif.err_cnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    init_model();
    repeat (15) @(negedge clk);
    chk("rst_no_ack", n_ack - ack0, 0);
    access(1'b0, 32'h0000_2000, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_mem_bridge.md
Name: pio_mem_bridge

Overview:
- PIO target-side bridge between the host PIO request bus and up to NUM_MEM PIO-accessible memory slaves.
- Decodes the memory select field of the host address and drives the per-memory select plus single-cycle rd/wr strobes.
- Waits for the selected slave's level ack, which is stretched to clk_div boundaries, then returns read data and ack to the host.
- Times out unresponsive slaves, rejects out-of-range selects, and counts errors.

Parameters:
- NUM_MEM, 4, number of attached memory slaves (1..2^SEL_NBITS).
- SEL_LSB, 12, LSB of the memory-select field in pio_addr.
- SEL_NBITS, 2, width of the memory-select field.
- TO_NBITS, 8, timeout counter width; timeout fires at 2^TO_NBITS-1 cycles.
- ERR_DATA, 32'hBAD0_0BAD, pio_rdata value returned on error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- pio_req  in  1  single-cycle host request strobe.
- pio_rw  in  1  1=write, 0=read; qualified by pio_req.
- pio_addr  in  `PIO_NBITS  host byte address.
- pio_wdata  in  `PIO_NBITS  host write data.
- pio_busy  out  1  bridge not in IDLE.
- pio_ack  out  1  single-cycle completion pulse.
- pio_err  out  1  error flag, valid with pio_ack.
- pio_rdata  out  `PIO_NBITS  read data; held between acks.
- err_cnt  out  16  saturating count of timeouts plus decode errors.
- reg_addr  out  `PIO_NBITS  latched address to slaves.
- reg_din  out  `PIO_NBITS  latched write data to slaves.
- reg_rd  out  1  one-cycle read strobe.
- reg_wr  out  1  one-cycle write strobe.
- reg_ms  out  NUM_MEM  one-hot slave select.
- mem_ack  in  NUM_MEM  per-slave level ack.
- mem_rdata  in  NUM_MEM*`PIO_NBITS  per-slave read data; slave i occupies slice i.

Behaviour:
- All outputs registered. Reset values: all outputs 0, and state=IDLE.
- States: IDLE, PRE, WAIT, RESP.
- IDLE:
  - On pio_req, latch rw, addr, wdata and sel=pio_addr[SEL_LSB+:SEL_NBITS].
  - If sel>=NUM_MEM, go to RESP with error; otherwise go to PRE and set reg_ms[sel]=1.
  - reg_addr and reg_din take the latched values at the same edge.
- PRE:
  - Waits for mem_ack[sel]==0, because a stale stretched ack from a prior access must clear first.
  - When seen low, pulse reg_rd or reg_wr for exactly one cycle and go to WAIT.
- WAIT:
  - On mem_ack[sel]==1, capture mem_rdata slice sel for reads (pio_rdata unchanged on writes) and go to RESP.
- RESP:
  - pio_ack=1 for one cycle, with pio_err set for error completions.
  - On error, pio_rdata=ERR_DATA for reads and writes alike.
  - reg_ms cleared, then return to IDLE.
- Timeout:
  - Counter cleared on entry to PRE; increments every cycle in PRE and WAIT.
  - At 2^TO_NBITS-1, abort to RESP with error. No strobe is issued if the abort happens in PRE.
- Error counting: err_cnt increments once per error completion and saturates at 16'hFFFF.
- pio_busy=1 in PRE, WAIT and RESP. A pio_req while busy is ignored: no queueing, no ack.
- Late acks: an ack arriving after a timeout is ignored. The next access to that slave holds in PRE until the ack drops.
- reg_addr, reg_din and reg_ms are stable from PRE entry through WAIT exit.
- Best-case latency: request cycle T → reg_ms at T+1 → strobe at T+2 → ack (earliest T+3) → pio_ack the cycle after the ack is sampled.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The in-flight host request is lost and not acknowledged.

Test Plan:
- Read mem 1: pio_addr=32'h0000_1008, mem_ack[1] asserted 3 cycles after reg_rd, mem_rdata slice1=32'h0001_2345 → reg_ms=4'b0010, reg_addr=32'h0000_1008, exactly one reg_rd pulse, pio_ack once with pio_rdata=32'h0001_2345 and pio_err=0.
- Write mem 2: addr 32'h0000_2010, data 32'hA5A5_0F0F, ack after 1 cycle → one reg_wr pulse, reg_din=32'hA5A5_0F0F, pio_ack with err=0, pio_rdata unchanged.
- Stale ack: mem_ack[0] held high for 5 cycles after a request to mem 0 → reg_rd is not issued until mem_ack[0] is low, then normal completion.
- Timeout: slave never acks, TO_NBITS=8 → pio_ack with pio_err=1 and pio_rdata=32'hBAD0_0BAD 255 cycles after PRE entry; err_cnt=1; a late ack is ignored.
- Decode error: NUM_MEM=3 and a request with sel=3 → no reg_ms or strobe, pio_ack with err=1 two cycles after the request, err_cnt increments.
- Busy and reset: a second pio_req during WAIT is ignored with a single ack total; rst asserted in WAIT → all outputs 0 immediately and no pio_ack.
